// File: rtl/gb_instr_feeder.sv
// rtl/gb_instr_feeder.sv - buffers program bytes and issues whole instructions to the gbprocessor core
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_byte/in_valid/in_ready  program byte stream into the FIFO
//   hold                   blocks pops while high (writes still accepted)
//   flush                  discards FIFO contents and any partial instruction
//   instruction/data/valid registered instruction to the core, one pulse per instruction
//   fifo_level             bytes currently buffered
//   issued_count           wrapping count of issued instructions
module gb_instr_feeder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     hold,
  input  logic                     flush,
  output logic [7:0]               instruction,
  output logic [7:0]               data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    OPCODE = 1'b0,
    IMM    = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [7:0]      op_reg;
  logic [7:0]      op_next;
  logic [7:0]      head;

  logic            wr_en;
  logic            pop;
  logic            issue;
  logic [7:0]      issue_instr;
  logic [7:0]      issue_data;

  function automatic logic is_two_byte(input logic [7:0] b);
    case (b)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E: is_two_byte = 1'b1;
      default:                                          is_two_byte = 1'b0;
    endcase
  endfunction

  // Full is judged from the level alone, so a full FIFO refuses a write
  // even in a cycle where it also pops.
  assign in_ready   = (level != LW'(DEPTH));
  assign wr_en      = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  // Both states consume one byte whenever allowed; the state only decides
  // what that byte means.
  assign pop = !hold && (level != '0);

  always_comb begin
    state_next  = state;
    op_next     = op_reg;
    issue       = 1'b0;
    issue_instr = instruction;
    issue_data  = data;
    case (state)
      OPCODE: begin
        if (pop) begin
          if (is_two_byte(head)) begin
            op_next    = head;
            state_next = IMM;
          end else begin
            issue       = 1'b1;
            issue_instr = head;
            issue_data  = 8'h00;
          end
        end
      end
      IMM: begin
        if (pop) begin
          issue       = 1'b1;
          issue_instr = op_reg;
          issue_data  = head;
          state_next  = OPCODE;
        end
      end
      default: state_next = OPCODE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= OPCODE;
    end else begin
      state <= state_next;
    end
  end

  // Storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && !flush && wr_en) begin
      mem[wr_ptr] <= in_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      op_reg       <= 8'h00;
      instruction  <= 8'h00;
      data         <= 8'h00;
      valid        <= 1'b0;
      issued_count <= '0;
    end else if (flush) begin
      // issued_count, instruction and data deliberately survive a flush.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level  <= level + LW'(wr_en) - LW'(pop);
      op_reg <= op_next;
      valid  <= issue;
      if (issue) begin
        instruction  <= issue_instr;
        data         <= issue_data;
        issued_count <= issued_count + CNT_W'(1);
      end
    end
  end

endmodule
